demux_dispatch_ctrl: RTL and testbench

Sequencing controller that sits in front of the 1-to-4 demultiplexer datapath. It accepts a single input stream over a valid/ready handshake, holds one word, and steers it to exactly one of four output channels. The target channel is either addressed explicitly (`in_sel`) or chosen round-robin. In round-robin mode a stalled channel is skipped after a timeout.

---
 rtl/demux_dispatch_ctrl.sv | 102 ++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_ctrl.sv
// One-word dispatch controller for the 1-to-4 demux: accepts a word and steers it
// to an addressed or round-robin channel, rerouting stalled round-robin words on timeout.
//
// state | meaning
// IDLE  | no word held, in_ready=1
// SEND  | word held, strobing out_valid[out_ch] until transfer
module demux_dispatch_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [3:0]       out_ready,
  output logic [1:0]       out_ch,
  output logic             reroute
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [7:0] WAIT_TC = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       ch_q, ch_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mode_q, mode_d;
  logic             reroute_q, reroute_d;
  logic             xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      ch_q       <= 2'd0;
      rr_ptr_q   <= 2'd0;
      wait_cnt_q <= 8'd0;
      mode_q     <= 1'b0;
      reroute_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      ch_q       <= ch_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      mode_q     <= mode_d;
      reroute_q  <= reroute_d;
    end
  end

  // Only the target channel's ready bit can complete a transfer.
  assign xfer = (state_q == SEND) && out_ready[ch_q];

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    ch_d       = ch_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    mode_d     = mode_q;
    reroute_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d     = in_data;
          mode_d     = mode;
          ch_d       = mode ? rr_ptr_q : in_sel;
          wait_cnt_d = 8'd0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          state_d = IDLE;
          if (mode_q) rr_ptr_d = ch_q + 2'd1;
        end else if (mode_q && (wait_cnt_q == WAIT_TC)) begin
          // Transfer has priority; timeout only moves an untaken word.
          ch_d       = ch_q + 2'd1;
          wait_cnt_d = 8'd0;
          reroute_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SEND) ? (4'b0001 << ch_q) : 4'b0000;
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign reroute   = reroute_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl: addressed, round-robin, timeout,
// addressed stall, reset mid-send, and transfer/timeout collision.
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       in_valid;
  logic [1:0] in_sel;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [3:0] out_ready;
  logic [1:0] out_ch;
  logic       reroute;

  int n_checks = 0;
  int n_errors = 0;

  demux_dispatch_ctrl #(.WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_sel(in_sel),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .out_ch(out_ch), .reroute(reroute)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Present one word for a single accept edge, then drop in_valid.
  task automatic send(input logic m, input logic [1:0] sel, input logic [7:0] d);
    mode     = m;
    in_sel   = sel;
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_reroute"}, 32'(reroute), 32'd0);
  endtask

  initial begin
    mode = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
    do_reset();
    check_idle("reset");
    check("reset_out_ch", 32'(out_ch), 32'd0);
    check("reset_out_data", 32'(out_data), 32'h00);

    // Addressed send to channel 2
    out_ready = 4'b1111;
    send(1'b0, 2'd2, 8'hA5);
    check("addr_out_valid", 32'(out_valid), 32'b0100);
    check("addr_out_data", 32'(out_data), 32'hA5);
    check("addr_out_ch", 32'(out_ch), 32'd2);
    check("addr_in_ready_busy", 32'(in_ready), 32'd0);
    step();
    check_idle("addr_done");

    // Round-robin, five words, wrapping 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 2'd3, 8'(8'h10 + i));
      check("rr_out_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
      check("rr_out_data", 32'(out_data), 32'(8'h10 + i));
      step();
      check("rr_in_ready", 32'(in_ready), 32'd1);
    end

    // Timeout on stalled channel 0
    do_reset();
    out_ready = 4'b1110;
    send(1'b1, 2'd0, 8'h3C);
    for (int c = 0; c < 15; c++) begin
      check("to_hold_valid", 32'(out_valid), 32'b0001);
      check("to_hold_reroute", 32'(reroute), 32'd0);
      step();
    end
    check("to_reroute", 32'(reroute), 32'd1);
    check("to_new_valid", 32'(out_valid), 32'b0010);
    check("to_new_ch", 32'(out_ch), 32'd1);
    check("to_data", 32'(out_data), 32'h3C);
    step();
    check_idle("to_xfer");
    send(1'b1, 2'd0, 8'h3D);
    check("to_next_ch", 32'(out_ch), 32'd2);
    check("to_next_valid", 32'(out_valid), 32'b0100);
    step();

    // Addressed stall on channel 3; mode/in_sel changes during SEND are ignored
    out_ready = 4'b0111;
    send(1'b0, 2'd3, 8'h5A);
    mode = 1'b1; in_sel = 2'd0;
    for (int c = 0; c < 40; c++) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_reroute", 32'(reroute), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'b1000);
      step();
    end
    check("stall_out_data", 32'(out_data), 32'h5A);
    out_ready = 4'b1111;
    step();
    check_idle("stall_done");
    // rr_ptr untouched by the addressed transfer: still 3
    send(1'b1, 2'd0, 8'h61);
    check("rr_ptr_kept", 32'(out_ch), 32'd3);
    step();
    send(1'b1, 2'd2, 8'h62);
    check("rr_wrap_ch", 32'(out_ch), 32'd0);
    step();

    // Reset while 0x77 is pending (rr_ptr is 1 beforehand)
    out_ready = 4'b0000;
    send(1'b0, 2'd1, 8'h77);
    check("pend_out_valid", 32'(out_valid), 32'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("midrst");
    check("midrst_out_data", 32'(out_data), 32'h00);
    check("midrst_out_ch", 32'(out_ch), 32'd0);
    out_ready = 4'b1111;
    send(1'b1, 2'd2, 8'h78);
    check("midrst_rr_ptr", 32'(out_ch), 32'd0);
    step();

    // Transfer coincident with timeout: transfer wins, no reroute
    do_reset();
    out_ready = 4'b0000;
    send(1'b1, 2'd0, 8'h99);
    for (int c = 0; c < 14; c++) step();
    check("coll_pre_valid", 32'(out_valid), 32'b0001);
    out_ready = 4'b0001;
    step();
    check_idle("coll");
    out_ready = 4'b1111;
    send(1'b1, 2'd0, 8'h9A);
    check("coll_next_ch", 32'(out_ch), 32'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
